// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks the digits with a dwell/gap
// cadence, double-buffers the displayed value and blanks leading zeros.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    lz_blank_en,
  output logic [3:0]              seg_data_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_OFF,
    S_DWELL,
    S_GAP
  } state_t;

  state_t                  state, nxt_state;
  logic [IW-1:0]           idx, nxt_idx;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic [4*NUM_DIGITS-1:0] active, nxt_active;
  logic [4*NUM_DIGITS-1:0] shadow, nxt_shadow;
  logic                    nxt_pending;
  logic                    wrap;
  logic                    off_path;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   nxt_sel;
  logic [3:0]              nxt_nibble;

  // Scan sequencing.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    wrap      = 1'b0;
    if (!enable) begin
      nxt_state = S_OFF;
      nxt_idx   = '0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        S_OFF: begin
          nxt_state = S_DWELL;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end
        S_DWELL: begin
          if (cnt == CW'(DWELL_CYCLES - 1)) begin
            nxt_state = S_GAP;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            nxt_state = S_DWELL;
            nxt_cnt   = '0;
            if (idx == IW'(NUM_DIGITS - 1)) begin
              nxt_idx = '0;
              wrap    = 1'b1;
            end else begin
              nxt_idx = idx + 1'b1;
            end
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: nxt_state = S_OFF;
      endcase
    end
  end

  // Double buffering: new values reach the active register only at a frame
  // wrap or while the display is off, so a frame never shows two values.
  always_comb begin
    nxt_active  = active;
    nxt_shadow  = shadow;
    nxt_pending = pending;
    off_path    = (state == S_OFF) || !enable;
    if (off_path || wrap) begin
      if (load) begin
        nxt_active = value_in;
      end else if (pending) begin
        nxt_active = shadow;
      end
      nxt_pending = 1'b0;
    end else if (load) begin
      nxt_shadow  = value_in;
      nxt_pending = 1'b1;
    end
  end

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero   = all_zero && (nxt_active[4*k +: 4] == 4'd0);
      lz_mask[k] = all_zero && (k != 0);
    end
  end

  always_comb begin
    nxt_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nxt_sel[k] = !((nxt_state == S_DWELL) && (nxt_idx == IW'(k)));
    end
    nxt_nibble = nxt_active[4*nxt_idx +: 4];
  end

  // Outputs are registered from the next-state values so they line up with the state.
  // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races between blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_OFF;
      idx          <= '0;
      cnt          <= '0;
      active       <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      seg_data_out <= 4'd0;
      digit_sel    <= '1;
      blank        <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state        <= nxt_state;
      idx          <= nxt_idx;
      cnt          <= nxt_cnt;
      active       <= nxt_active;
      shadow       <= nxt_shadow;
      pending      <= nxt_pending;
      digit_sel    <= nxt_sel;
      frame_done   <= wrap;
      blank        <= (nxt_state != S_DWELL) || (lz_blank_en && lz_mask[nxt_idx]);
      if (nxt_state == S_DWELL) begin
        seg_data_out <= nxt_nibble;
      end
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed 7-segment digits.
REQ-002 SHALL have parameter DWELL_CYCLES, default 50000, meaning the clock cycles each digit is driven; legal range >=1.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, meaning the all-off anti-ghosting cycles between digits; legal range >=1.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset; synchronous, active-high.
REQ-006 SHALL have port enable, input, 1 bit; 1 = scanning runs, 0 = display off.
REQ-007 SHALL have port load, input, 1 bit; single-cycle request to capture value_in.
REQ-008 SHALL have port value_in, input, 4*NUM_DIGITS bits; BCD nibbles, with digit k at bits [4k+3:4k] and digit 0 the least significant.
REQ-009 SHALL have port lz_blank_en, input, 1 bit; 1 = leading-zero blanking is enabled.
REQ-010 SHALL have port seg_data_out, output, 4 bits; the nibble fed to the shared segment decoder.
REQ-011 SHALL have port digit_sel, output, NUM_DIGITS bits; active-low one-hot digit enables.
REQ-012 SHALL have port blank, output, 1 bit; 1 = segment drivers forced off.
REQ-013 SHALL have port pending, output, 1 bit; 1 = a loaded value is waiting for the frame boundary.
REQ-014 SHALL have port frame_done, output, 1 bit; one-cycle pulse at each frame wrap.

Function
REQ-015 SHALL register all outputs, with no combinational input-to-output path.
REQ-016 SHALL implement states OFF, DWELL and GAP, plus a digit index idx in 0..NUM_DIGITS-1 and a cycle counter cnt.
REQ-017 SHALL, in OFF with enable=1, enter DWELL with idx=0 and cnt=0 on the next cycle.
REQ-018 SHALL, in DWELL, increment cnt each cycle, and on cnt=DWELL_CYCLES-1 enter GAP with cnt=0.
REQ-019 SHALL, in GAP, increment cnt each cycle, and on cnt=GAP_CYCLES-1 enter DWELL with idx advanced, wrapping from NUM_DIGITS-1 to 0, and cnt=0.
REQ-020 SHALL pulse frame_done for one cycle, coincident with entering DWELL at idx=0 from GAP; the initial entry from OFF does not pulse.
REQ-021 SHALL, when enable=0 in any state, enter OFF on the next cycle with idx=0 and cnt=0; active and shadow registers are retained.
REQ-022 SHALL drive digit_sel with bit idx low and all other bits high while in DWELL, and all ones in OFF and GAP.
REQ-023 SHALL drive seg_data_out with nibble idx of the active register while in DWELL, and hold its last value otherwise.
REQ-024 SHALL drive blank=1 in OFF and GAP, and in DWELL when digit idx is a leading zero; otherwise blank=0.
REQ-025 SHALL treat digit k as a leading zero iff lz_blank_en=1, k>0, and all active nibbles k..NUM_DIGITS-1 are 0; digit 0 is never blanked.
REQ-026 SHALL, on load=1, capture value_in into the shadow register and set pending=1 next cycle; a load while pending=1 overwrites the shadow (latest wins).
REQ-027 SHALL copy shadow to active and clear pending at the frame wrap (the GAP->DWELL idx=0 transition), so a displayed frame never mixes two values.
REQ-028 SHALL, when load=1 coincides with a frame wrap, write value_in directly to active and leave pending=0.
REQ-029 SHALL, when load=1 while in OFF, write value_in directly to active with pending=0; a shadow pending at OFF entry is also copied to active.
REQ-030 SHALL pass nibbles above 9 unmodified; decoding is the decoder's responsibility.

Reset
REQ-031 SHALL, while rst=1 (overriding all inputs), force state=OFF, idx=0, cnt=0, active=0, shadow=0, pending=0, seg_data_out=0, digit_sel=all ones, blank=1, frame_done=0.
REQ-032 SHALL, on rst asserted mid-scan, discard a pending value and start from OFF on the first cycle after rst falls.

Verification (NUM_DIGITS=4, DWELL_CYCLES=4, GAP_CYCLES=1)
REQ-033 SHALL verify reset then enable=1, with a load of 16'h1234 in OFF: digit_sel cycles 1110, 1101, 1011, 0111 for 4 cycles each, separated by single 1111 cycles; seg_data_out is 4, 3, 2, 1; frame period is 20 cycles; frame_done pulses every 20 cycles.
REQ-034 SHALL verify a mid-frame load of 16'h5678 at digit 1: pending=1, the remaining digits still show 1234 values, and the next frame shows 8, 7, 6, 5 with pending=0.
REQ-035 SHALL verify two loads (16'h1111 then 16'h2222) within one frame: only 2222 is displayed next frame.
REQ-036 SHALL verify lz_blank_en=1 with active 16'h0070: blank=1 during digits 3 and 2, and blank=0 for digits 1 (7) and 0 (0); with 16'h0000 only digit 0 is unblanked.
REQ-037 SHALL verify enable dropped during GAP of digit 2: next cycle state is OFF, digit_sel=1111, blank=1; on re-enable, scanning restarts at digit 0 with no frame_done pulse.
REQ-038 SHALL verify rst pulsed mid-DWELL with pending=1: all outputs take their reset values and pending=0.
